clock_div_ctrl: RTL
===================

CLOCK_DIV_CTRL -- requirements
Module: clock_div_ctrl

Interface
REQ-001 Parameter: SIZE, default 3, width of the divide value.
REQ-002 Parameter: DEFAULT_N, default 2, divide value after reset.
REQ-003 Parameter: HOLD_CYC, default 4, cycles the divider is held in reset per reprogram (legal range 1..15).
REQ-004 Parameter: SETTLE_CYC, default 32, wait cycles after divider reset release (legal range 1..255).
REQ-005 wb_clk_i  input  1  the single block clock; one clock; all logic on its rising edge.
REQ-006 wb_rst_i  input  1  reset, synchronous, active-high.
REQ-007 req_i  input  2  per-requester request level (bit 0 housekeeping SPI, bit 1 CPU bus).
REQ-008 req_n0_i / req_n1_i  input  SIZE each  requested divide value, valid while the matching req_i bit is high.
REQ-009 ack_o  output  2  one-cycle completion pulse per requester.
REQ-010 err_o  output  2  one-cycle rejection pulse per requester.
REQ-011 div_n_o  output  SIZE  divide value driven to the divider.
REQ-012 div_resetb_o  output  1  active-low reset driven to the divider.
REQ-013 busy_o  output  1  high while in HOLD or SETTLE.

Function
REQ-014 FSM states SHALL be IDLE, HOLD, SETTLE and DONE; all outputs SHALL be registered.
REQ-015 In IDLE with any req_i bit high, the 2-way round-robin arbiter SHALL grant one requester; when both are high, the one not granted last wins.
REQ-016 The arbiter pointer SHALL update on every grant, including rejected and no-change grants.
REQ-017 At the grant edge, the granted value SHALL be latched; value 1 is illegal, since the divider outputs a constant 0 for N=1.
REQ-018 Illegal value: FSM SHALL go to DONE and pulse err_o for the winner; div_n_o and div_resetb_o are unchanged.
REQ-019 Value equal to div_n_o: FSM SHALL go to DONE and pulse ack_o with no divider reset.
REQ-020 Otherwise: FSM SHALL go to HOLD, load div_n_o and drive div_resetb_o=0 in the same edge.
REQ-021 HOLD SHALL last exactly HOLD_CYC cycles, then SETTLE with div_resetb_o=1 for exactly SETTLE_CYC cycles, then DONE.
REQ-022 DONE SHALL last exactly one cycle: ack_o/err_o high for the granted bit only, then IDLE; req_i is not sampled in DONE.
REQ-023 Latency: request sampled at cycle 0 gives ack at cycle HOLD_CYC+SETTLE_CYC+1 (37 with defaults), or cycle 1 for reject/no-change.
REQ-024 Deasserting req_i mid-operation SHALL NOT abort the sequence; the ack is still pulsed.
REQ-025 req_n*_i changes after the grant SHALL be ignored until the next grant.
REQ-026 Value 0 (divide-by-1) SHALL be legal.
REQ-027 Wait counters SHALL be 8 bits and count down; no wrap-around is permitted.

Reset
REQ-028 wb_rst_i SHALL set: state IDLE, div_n_o=DEFAULT_N, div_resetb_o=0, ack_o=0, err_o=0, busy_o=0, and the arbiter pointer so requester 0 wins first.
REQ-029 div_resetb_o SHALL go to 1 in the first cycle after wb_rst_i deasserts.
REQ-030 wb_rst_i asserted mid-sequence SHALL abort it with no ack/err pulse, and div_n_o returns to DEFAULT_N.

Structure
REQ-031 A shared package/defines file SHALL hold the state encoding (2 bits) and the DEFAULT_N, HOLD_CYC and SETTLE_CYC defaults.
REQ-032 The round-robin arbiter SHALL be a sub-module named rr_arb2 (req, grant, advance, pointer register); all else stays in clock_div_ctrl.

Verification
REQ-033 Reset, then req_i=01, N=5 at cycle 0 -> div_resetb_o low cycles 1-4, div_n_o=5 from cycle 1, busy_o high 1-36, ack_o=01 at cycle 37.
REQ-034 req_i=10, N=1 -> err_o=10 at cycle 1; div_n_o stays 2; div_resetb_o stays 1.
REQ-035 req_i=01, N=2 right after reset -> ack_o=01 at cycle 1; div_resetb_o never low.
REQ-036 req_i=11 held with N0=3, N1=4 -> requester 0 acked first with div_n_o=3, then requester 1 with div_n_o=4; no back-to-back grant to the same requester.
REQ-037 wb_rst_i pulsed at cycle 10 of a reprogram to N=6 -> no ack, div_n_o=2, div_resetb_o=1 one cycle after reset ends, FSM idle.
REQ-038 req_i dropped at cycle 3 of a reprogram, and req_n0_i changed at cycle 2 -> sequence completes with the originally latched value, ack_o pulses at cycle 37.

Source files
------------

// File: rtl/clock_div_ctrl_pkg.sv
// ============================================================================
//  Module   : clock_div_ctrl_pkg
//  Brief    : Shared state encoding and default timing for clock_div_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package clock_div_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int c_DEFAULT_N  = 2;
  localparam int c_HOLD_CYC   = 4;
  localparam int c_SETTLE_CYC = 32;
  localparam int c_CNT_W      = 8;

endpackage

`default_nettype wire

// File: rtl/clock_div_ctrl_rr_arb2.sv
// ============================================================================
//  Module   : rr_arb2
//  Brief    : Two-way round-robin arbiter with a one-bit priority pointer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  // ptr_q names the requester that wins a tie
  logic ptr_q;
  logic ptr_d;

  always_comb begin
    grant_o = req_i;
    if (req_i == 2'b11) begin
      grant_o = ptr_q ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && (grant_o != 2'b00)) begin
      ptr_d = grant_o[0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/clock_div_ctrl.sv
// ============================================================================
//  Module   : clock_div_ctrl
//  Brief    : Arbitrated reprogramming of a clock divider with hold/settle.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_div_ctrl
  import clock_div_ctrl_pkg::*;
#(
  parameter int SIZE       = 3,
  parameter int DEFAULT_N  = c_DEFAULT_N,
  parameter int HOLD_CYC   = c_HOLD_CYC,
  parameter int SETTLE_CYC = c_SETTLE_CYC
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [1:0]      req_i,
  input  logic [SIZE-1:0] req_n0_i,
  input  logic [SIZE-1:0] req_n1_i,
  output logic [1:0]      ack_o,
  output logic [1:0]      err_o,
  output logic [SIZE-1:0] div_n_o,
  output logic            div_resetb_o,
  output logic            busy_o
);

  state_e              state_q, state_d;
  logic [c_CNT_W-1:0]  cnt_q, cnt_d;
  logic [SIZE-1:0]     div_n_q, div_n_d;
  logic                div_resetb_q, div_resetb_d;
  logic                busy_q, busy_d;
  logic [1:0]          ack_q, ack_d;
  logic [1:0]          err_q, err_d;
  logic [1:0]          gnt_q, gnt_d;

  logic [1:0]          w_grant;
  logic                w_advance;
  logic [SIZE-1:0]     w_req_n;

  rr_arb2 u_arb (
    .clk_i     (wb_clk_i),
    .rst_i     (wb_rst_i),
    .req_i     (req_i),
    .advance_i (w_advance),
    .grant_o   (w_grant)
  );

  assign w_req_n = w_grant[1] ? req_n1_i : req_n0_i;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    div_n_d      = div_n_q;
    div_resetb_d = 1'b1;
    busy_d       = 1'b0;
    ack_d        = 2'b00;
    err_d        = 2'b00;
    gnt_d        = gnt_q;
    w_advance    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_i != 2'b00) begin
          w_advance = 1'b1;
          gnt_d     = w_grant;
          // N=1 would stall the divider output at 0, so it is refused
          if (w_req_n == SIZE'(1)) begin
            state_d = ST_DONE;
            err_d   = w_grant;
          end else if (w_req_n == div_n_q) begin
            state_d = ST_DONE;
            ack_d   = w_grant;
          end else begin
            state_d      = ST_HOLD;
            div_n_d      = w_req_n;
            div_resetb_d = 1'b0;
            busy_d       = 1'b1;
            cnt_d        = c_CNT_W'(HOLD_CYC - 1);
          end
        end
      end

      ST_HOLD: begin
        busy_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_SETTLE;
          cnt_d   = c_CNT_W'(SETTLE_CYC - 1);
        end else begin
          div_resetb_d = 1'b0;
          cnt_d        = cnt_q - 1'b1;
        end
      end

      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          ack_d   = gnt_q;
        end else begin
          busy_d = 1'b1;
          cnt_d  = cnt_q - 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      div_n_q      <= SIZE'(DEFAULT_N);
      div_resetb_q <= 1'b0;
      busy_q       <= 1'b0;
      ack_q        <= 2'b00;
      err_q        <= 2'b00;
      gnt_q        <= 2'b00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      div_n_q      <= div_n_d;
      div_resetb_q <= div_resetb_d;
      busy_q       <= busy_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      gnt_q        <= gnt_d;
    end
  end

  assign ack_o        = ack_q;
  assign err_o        = err_q;
  assign div_n_o      = div_n_q;
  assign div_resetb_o = div_resetb_q;
  assign busy_o       = busy_q;

endmodule

`default_nettype wire
